// File: rtl/hazard_forward_unit_pkg.sv
// hfu_pkg: shared constants, field-offset helpers and the per-stage record
// used by hazard_forward_unit and hfu_stage_reg.
//   - opcode classes (NOP, LD, ST, JMP, COND_J prefix, IMM prefix)
//   - field LSB helpers: opcode, RW, RA, RB packed from the MSB downwards
//   - stage_t: what each tracked pipeline stage remembers
package hfu_pkg;

    localparam int OPC_W = 5;

    localparam logic [4:0] OP_NOP     = 5'b00000;
    localparam logic [4:0] OP_LD      = 5'b10100;
    localparam logic [4:0] OP_ST      = 5'b10101;
    localparam logic [4:0] OP_JMP     = 5'b11000;
    localparam logic [2:0] OP_CJ_PFX  = 3'b111;
    localparam logic [1:0] OP_IMM_PFX = 2'b01;

    localparam int SEL_REGFILE = 0;

    // Destination field is stored at a fixed width so the struct does not
    // depend on REG_AW; narrower register addresses are zero-extended.
    localparam int DEST_W = 8;

    typedef struct packed {
        logic              valid;
        logic [DEST_W-1:0] dest;
        logic              writes_reg;
        logic              is_ld;
        logic              is_st;
    } stage_t;

    function automatic int op_lsb(int ins_w, int op_w);
        return ins_w - op_w;
    endfunction

    function automatic int rw_lsb(int ins_w, int op_w, int reg_aw);
        return ins_w - op_w - reg_aw;
    endfunction

    function automatic int ra_lsb(int ins_w, int op_w, int reg_aw);
        return ins_w - op_w - 2 * reg_aw;
    endfunction

    function automatic int rb_lsb(int ins_w, int op_w, int reg_aw);
        return ins_w - op_w - 3 * reg_aw;
    endfunction

    // Control transfers neither read nor write the register file.
    function automatic logic is_ctl(logic [4:0] op);
        return (op == OP_JMP) || (op[4:2] == OP_CJ_PFX);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// hazard_forward_unit_if: fetch-side inputs and forwarding/memory controls.
//   master: ins_valid, ins, flush out; everything else in
//   slave : the forwarding unit side
// With HFU_STALL_CNT_EN defined the bundle also carries stall_count[15:0].
interface hazard_forward_unit_if #(
    parameter int INS_W     = 24,
    parameter int OP_W      = 5,
    parameter int REG_AW    = 5,
    parameter int IMM_W     = 8,
    parameter int FWD_DEPTH = 3
);
    localparam int SEL_W = $clog2(FWD_DEPTH + 1);

    logic              ins_valid;
    logic [INS_W-1:0]  ins;
    logic              flush;
    logic              stall;
    logic [OP_W-1:0]   op_dec;
    logic [IMM_W-1:0]  imm;
    logic              imm_sel;
    logic [SEL_W-1:0]  mux_sel_A;
    logic [SEL_W-1:0]  mux_sel_B;
    logic [REG_AW-1:0] RW_dm;
    logic              mem_en_ex;
    logic              mem_rw_ex;
    logic              mem_mux_sel_dm;
`ifdef HFU_STALL_CNT_EN
    logic [15:0]       stall_count;
`endif

    modport master (
        output ins_valid, ins, flush,
        input  stall, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B, RW_dm,
               mem_en_ex, mem_rw_ex, mem_mux_sel_dm
`ifdef HFU_STALL_CNT_EN
        , input stall_count
`endif
    );

    modport slave (
        input  ins_valid, ins, flush,
        output stall, op_dec, imm, imm_sel, mux_sel_A, mux_sel_B, RW_dm,
               mem_en_ex, mem_rw_ex, mem_mux_sel_dm
`ifdef HFU_STALL_CNT_EN
        , output stall_count
`endif
    );

endinterface

// File: rtl/hazard_forward_unit_stage_reg.sv
// hfu_stage_reg: one tracked pipeline stage (stage_t) register.
//   clk, reset : clock, synchronous active-high reset
//   kill       : load a bubble instead of d (branch flush)
//   d / q      : incoming / held stage record
module hfu_stage_reg
    import hfu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   kill,
    input  stage_t d,
    output stage_t q
);

    always_ff @(posedge clk) begin
        if (reset || kill) q <= '0;
        else               q <= d;
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: decode register, FWD_DEPTH tracked stages, operand
// forwarding selects, load-use stall with bubble insertion and branch flush.
//   clk, reset : clock, synchronous active-high reset
//   bus        : hazard_forward_unit_if.slave (ins in, controls out)
// Optional: HFU_STALL_CNT_EN adds a saturating 16-bit stall cycle counter.
module hazard_forward_unit
    import hfu_pkg::*;
#(
    parameter int INS_W     = 24,
    parameter int OP_W      = 5,
    parameter int REG_AW    = 5,
    parameter int IMM_W     = 8,
    parameter int FWD_DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    hazard_forward_unit_if.slave  bus
);

    localparam int SEL_W  = $clog2(FWD_DEPTH + 1);
    localparam int OP_LSB = op_lsb(INS_W, OP_W);
    localparam int RW_LSB = rw_lsb(INS_W, OP_W, REG_AW);
    localparam int RA_LSB = ra_lsb(INS_W, OP_W, REG_AW);
    localparam int RB_LSB = rb_lsb(INS_W, OP_W, REG_AW);

    // Fields of the incoming word
    logic [OP_W-1:0]   ins_op;
    logic [4:0]        ins_op5;
    logic [REG_AW-1:0] ins_rw, ins_ra, ins_rb;
    logic              ins_rd, ins_wr;

    assign ins_op  = bus.ins[OP_LSB +: OP_W];
    assign ins_op5 = ins_op[OP_W-1 -: OPC_W];
    assign ins_rw  = bus.ins[RW_LSB +: REG_AW];
    assign ins_ra  = bus.ins[RA_LSB +: REG_AW];
    assign ins_rb  = bus.ins[RB_LSB +: REG_AW];
    assign ins_rd  = bus.ins_valid && !is_ctl(ins_op5);
    assign ins_wr  = bus.ins_valid && !is_ctl(ins_op5) && (ins_op5 != OP_NOP)
                     && (ins_op5 != OP_ST) && (ins_rw != '0);

    // Decode register
    logic              dec_valid, dec_wr, dec_ld, dec_st, dec_imm_sel;
    logic [OP_W-1:0]   dec_op;
    logic [REG_AW-1:0] dec_rw, dec_ra, dec_rb;
    logic [IMM_W-1:0]  dec_imm;
    logic              stall_int;

    // The loaded value is not available until dm, so a reader directly
    // behind a load must wait one cycle. Flush wins: the reader is dead.
    assign stall_int = !reset && !bus.flush && dec_ld && dec_wr && ins_rd
                       && ((ins_ra == dec_rw) || (ins_rb == dec_rw));

    always_ff @(posedge clk) begin
        if (reset || bus.flush || stall_int || !bus.ins_valid) begin
            dec_valid   <= 1'b0;
            dec_wr      <= 1'b0;
            dec_ld      <= 1'b0;
            dec_st      <= 1'b0;
            dec_imm_sel <= 1'b0;
            dec_op      <= '0;
            dec_rw      <= '0;
            dec_ra      <= '0;
            dec_rb      <= '0;
            dec_imm     <= '0;
        end else begin
            dec_valid   <= 1'b1;
            dec_wr      <= ins_wr;
            dec_ld      <= (ins_op5 == OP_LD);
            dec_st      <= (ins_op5 == OP_ST);
            dec_imm_sel <= (ins_op5[4:3] == OP_IMM_PFX);
            dec_op      <= ins_op;
            dec_rw      <= ins_rw;
            // Non-readers get r0 so they never match a forward source.
            dec_ra      <= ins_rd ? ins_ra : '0;
            dec_rb      <= ins_rd ? ins_rb : '0;
            dec_imm     <= bus.ins[IMM_W:1];
        end
    end

    // Tracked stages 1..FWD_DEPTH (1 = ex, 2 = dm, ...)
    stage_t dec_stg;
    stage_t stg_q [1:FWD_DEPTH];

    always_comb begin
        dec_stg            = '0;
        dec_stg.valid      = dec_valid;
        dec_stg.dest       = DEST_W'(dec_rw);
        dec_stg.writes_reg = dec_wr;
        dec_stg.is_ld      = dec_ld;
        dec_stg.is_st      = dec_st;
    end

    for (genvar k = 1; k <= FWD_DEPTH; k++) begin : g_stage
        stage_t d;
        if (k == 1) begin : g_first
            assign d = dec_stg;
        end else begin : g_rest
            assign d = stg_q[k-1];
        end
        hfu_stage_reg u_stage (
            .clk   (clk),
            .reset (reset),
            .kill  ((k == 1) && bus.flush),
            .d     (d),
            .q     (stg_q[k])
        );
    end

    // Forwarding: scan oldest to youngest so the youngest match sticks.
    logic [SEL_W-1:0] sel_a, sel_b;

    always_comb begin
        sel_a = SEL_W'(SEL_REGFILE);
        sel_b = SEL_W'(SEL_REGFILE);
        for (int k = FWD_DEPTH; k >= 1; k--) begin
            if (stg_q[k].valid && stg_q[k].writes_reg) begin
                if (dec_ra != '0 && stg_q[k].dest == DEST_W'(dec_ra)) sel_a = SEL_W'(k);
                if (dec_rb != '0 && stg_q[k].dest == DEST_W'(dec_rb)) sel_b = SEL_W'(k);
            end
        end
    end

    assign bus.stall          = stall_int;
    assign bus.op_dec         = dec_op;
    assign bus.imm            = dec_imm;
    assign bus.imm_sel        = dec_imm_sel;
    assign bus.mux_sel_A      = sel_a;
    assign bus.mux_sel_B      = sel_b;
    assign bus.mem_en_ex      = stg_q[1].is_ld || stg_q[1].is_st;
    assign bus.mem_rw_ex      = stg_q[1].is_st;
    assign bus.mem_mux_sel_dm = stg_q[2].is_ld;
    assign bus.RW_dm          = stg_q[2].writes_reg ? stg_q[2].dest[REG_AW-1:0] : '0;

`ifdef HFU_STALL_CNT_EN
    logic [15:0] stall_cnt;
    always_ff @(posedge clk) begin
        if (reset)                               stall_cnt <= '0;
        else if (stall_int && stall_cnt != '1)   stall_cnt <= stall_cnt + 16'd1;
    end
    assign bus.stall_count = stall_cnt;
`endif

    // Low instruction bits below the immediate, and high dest bits, may be
    // don't-cares for a given parameterisation.
    logic unused_bits;
    assign unused_bits = ^{bus.ins, dec_valid};

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;
    import hfu_pkg::*;

    typedef struct {
        bit          rst;
        bit          v;
        logic [23:0] ins;
        bit          fl;
        bit          stall;
        logic [4:0]  op;
        logic [1:0]  sa, sb;
        bit          men, mrw, mdm;
        logic [4:0]  rwdm;
        bit          isel;
        bit          ci;
        logic [7:0]  imm;
    } vec_t;

    localparam logic [4:0] ADD = 5'b00001;
    localparam logic [4:0] CJ  = 5'b11100;
    localparam logic [4:0] IMO = 5'b01000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hazard_forward_unit_if #(.FWD_DEPTH(3)) bus ();

    hazard_forward_unit #(.FWD_DEPTH(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    vec_t vecs[$];
    vec_t sb_q[$];
    int checks = 0;
    int failures = 0;

    function automatic logic [23:0] mk(logic [4:0] op, logic [4:0] rw, logic [4:0] ra,
                                       logic [4:0] rb, logic [3:0] lo = 4'h0);
        return {op, rw, ra, rb, lo};
    endfunction

    // Normal row: inputs for this cycle and outputs expected in the same cycle.
    task automatic t(bit v, logic [23:0] ins, bit fl, bit st, logic [4:0] op,
                     logic [1:0] sa, logic [1:0] sb, bit men, bit mrw, bit mdm,
                     logic [4:0] rwdm, bit isel = 0, bit ci = 0, logic [7:0] imm = 0);
        vec_t e;
        e.rst = 0; e.v = v; e.ins = ins; e.fl = fl; e.stall = st; e.op = op;
        e.sa = sa; e.sb = sb; e.men = men; e.mrw = mrw; e.mdm = mdm; e.rwdm = rwdm;
        e.isel = isel; e.ci = ci; e.imm = imm;
        vecs.push_back(e);
    endtask

    // Reset row: only stall (forced low) is defined before the edge.
    task automatic r(bit v, logic [23:0] ins);
        vec_t e;
        e = '{default: 0};
        e.rst = 1; e.v = v; e.ins = ins;
        vecs.push_back(e);
    endtask

    task automatic cmp(string nm, int row, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
        end
    endtask

    initial begin
        vec_t e;
        int cnt_exp;
        bit cnt_known;
        cnt_exp = 0;
        cnt_known = 0;
        reset = 1'b1;
        bus.ins_valid = 1'b0;
        bus.ins = '0;
        bus.flush = 1'b0;

        // reset with random traffic, then first instruction and RAW distance 1
        for (int i = 0; i < 3; i++) r(1, 24'($urandom));
        t(1, mk(ADD,3,1,2), 0,  0, 0,     0,0, 0,0,0, 0);
        t(1, mk(ADD,4,3,3), 0,  0, ADD,   0,0, 0,0,0, 0);
        t(0, 0,             0,  0, ADD,   1,1, 0,0,0, 0);
        t(0, 0,             0,  0, 0,     0,0, 0,0,0, 3);
        // distance 2
        r(0, 0);
        t(1, mk(ADD,3,1,2), 0,  0, 0,     0,0, 0,0,0, 0);
        t(1, mk(0,0,0,0),   0,  0, ADD,   0,0, 0,0,0, 0);
        t(1, mk(ADD,4,3,3), 0,  0, 0,     0,0, 0,0,0, 0);
        t(0, 0,             0,  0, ADD,   2,2, 0,0,0, 3);
        // distance 3
        r(0, 0);
        t(1, mk(ADD,3,1,2), 0,  0, 0,     0,0, 0,0,0, 0);
        t(1, mk(0,0,0,0),   0,  0, ADD,   0,0, 0,0,0, 0);
        t(1, mk(0,0,0,0),   0,  0, 0,     0,0, 0,0,0, 0);
        t(1, mk(ADD,4,3,3), 0,  0, 0,     0,0, 0,0,0, 3);
        t(0, 0,             0,  0, ADD,   3,3, 0,0,0, 0);
        // distance 4: beyond the tracked window
        r(0, 0);
        t(1, mk(ADD,3,1,2), 0,  0, 0,     0,0, 0,0,0, 0);
        t(1, mk(0,0,0,0),   0,  0, ADD,   0,0, 0,0,0, 0);
        t(1, mk(0,0,0,0),   0,  0, 0,     0,0, 0,0,0, 0);
        t(1, mk(0,0,0,0),   0,  0, 0,     0,0, 0,0,0, 3);
        t(1, mk(ADD,4,3,3), 0,  0, 0,     0,0, 0,0,0, 0);
        t(0, 0,             0,  0, ADD,   0,0, 0,0,0, 0);
        // r0 never forwards; youngest writer wins
        r(0, 0);
        t(1, mk(ADD,0,1,2), 0,  0, 0,     0,0, 0,0,0, 0);
        t(1, mk(ADD,6,0,0), 0,  0, ADD,   0,0, 0,0,0, 0);
        t(1, mk(ADD,5,1,2), 0,  0, ADD,   0,0, 0,0,0, 0);
        t(1, mk(ADD,5,1,2), 0,  0, ADD,   0,0, 0,0,0, 0);
        t(1, mk(ADD,6,5,5), 0,  0, ADD,   0,0, 0,0,0, 6);
        t(0, 0,             0,  0, ADD,   1,1, 0,0,0, 5);
        // load-use: one bubble, then forward from dm
        r(0, 0);
        t(1, mk(OP_LD,7,0,0),  0,  0, 0,     0,0, 0,0,0, 0);
        t(1, mk(ADD,8,7,1),    0,  1, OP_LD, 0,0, 0,0,0, 0);
        t(1, mk(ADD,8,7,1),    0,  0, 0,     0,0, 1,0,0, 0);
        t(0, 0,                0,  0, ADD,   2,0, 0,0,1, 7);
        // memory pipeline: store then load
        r(0, 0);
        t(1, mk(OP_ST,2,3,0),  0,  0, 0,     0,0, 0,0,0, 0);
        t(1, mk(OP_LD,9,1,0),  0,  0, OP_ST, 0,0, 0,0,0, 0);
        t(0, 0,                0,  0, OP_LD, 0,0, 1,1,0, 0);
        t(0, 0,                0,  0, 0,     0,0, 1,0,0, 0);
        t(0, 0,                0,  0, 0,     0,0, 0,0,1, 9);
        // flush beats stall; stage 2 survives
        r(0, 0);
        t(1, mk(ADD,10,1,2),   0,  0, 0,     0,0, 0,0,0, 0);
        t(1, mk(OP_LD,7,0,0),  0,  0, ADD,   0,0, 0,0,0, 0);
        t(1, mk(ADD,8,7,1),    1,  0, OP_LD, 0,0, 0,0,0, 0);
        t(0, 0,                0,  0, 0,     0,0, 0,0,0, 10);
        // branch reads nothing; immediate decode
        r(0, 0);
        t(1, mk(OP_LD,7,0,0),        0,  0, 0,     0,0, 0,0,0, 0);
        t(1, mk(CJ,0,7,7),           0,  0, OP_LD, 0,0, 0,0,0, 0);
        t(1, mk(IMO,1,0,22,4'b1011), 0,  0, CJ,    0,0, 1,0,0, 0);
        t(0, 0,                      0,  0, IMO,   0,0, 0,0,1, 7, 1, 1, 8'hB5);
        // reset while a load-use hazard is pending
        r(0, 0);
        t(1, mk(OP_LD,7,0,0),  0,  0, 0,     0,0, 0,0,0, 0);
        r(1, mk(ADD,8,7,1));
        t(1, mk(ADD,8,7,1),    0,  0, 0,     0,0, 0,0,0, 0);
        t(0, 0,                0,  0, ADD,   0,0, 0,0,0, 0);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            reset = vecs[i].rst;
            bus.ins_valid = vecs[i].v;
            bus.ins = vecs[i].ins;
            bus.flush = vecs[i].fl;
            sb_q.push_back(vecs[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            cmp("stall", i, 32'(bus.stall), 32'(e.stall));
            if (!e.rst) begin
                cmp("op_dec",         i, 32'(bus.op_dec),         32'(e.op));
                cmp("mux_sel_A",      i, 32'(bus.mux_sel_A),      32'(e.sa));
                cmp("mux_sel_B",      i, 32'(bus.mux_sel_B),      32'(e.sb));
                cmp("mem_en_ex",      i, 32'(bus.mem_en_ex),      32'(e.men));
                cmp("mem_rw_ex",      i, 32'(bus.mem_rw_ex),      32'(e.mrw));
                cmp("mem_mux_sel_dm", i, 32'(bus.mem_mux_sel_dm), 32'(e.mdm));
                cmp("RW_dm",          i, 32'(bus.RW_dm),          32'(e.rwdm));
                cmp("imm_sel",        i, 32'(bus.imm_sel),        32'(e.isel));
                if (e.ci) cmp("imm", i, 32'(bus.imm), 32'(e.imm));
            end
`ifdef HFU_STALL_CNT_EN
            if (cnt_known) cmp("stall_count", i, 32'(bus.stall_count), 32'(cnt_exp));
            if (e.rst) begin
                cnt_exp = 0;
                cnt_known = 1;
            end else if (e.stall) begin
                cnt_exp++;
            end
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
